ad9911_serial_writer: RTL

//  Responder end of the TR/ADDR/DATA/BUSY register-write interface driven by the AD9911 init/frequency-update logic.

---
 rtl/ad9911_serial_writer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ad9911_serial_writer.sv
// AD9911 register-write serialiser.
// Accepts one write per TR rising edge and shifts {instruction, data bytes} out MSB first
// on the 3-wire SPI port (SCLK/CS_N/SDIO), holding BUSY for the whole transaction.
// Optional feature macro: AUTO_IO_UPDATE_EN -- when defined, IO_UPDATE is pulsed for
// IOUPD_LEN cycles after each frame; when undefined, IO_UPDATE is tied low.
// After the last SCLK high phase there is one CS_HOLD cycle (CS_N low, SCLK low) and one
// CS_REC cycle with CS_N already high before the transaction ends, giving a fixed
// 3-cycle framing overhead around the 2*SCLK_DIV cycles per bit.

module ad9911_serial_writer #(
    parameter int unsigned SCLK_DIV  = 1,
    parameter int unsigned IOUPD_LEN = 2
) (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic        TR,
    input  logic [7:0]  ADDR,
    input  logic [31:0] DATA,
    output logic        BUSY,
    output logic        ERR,
    output logic        SCLK,
    output logic        CS_N,
    output logic        SDIO,
    output logic        IO_UPDATE
);

    localparam int unsigned DIV_W  = $clog2(SCLK_DIV) + 1;
    localparam int unsigned BITS_W = 6;
    localparam int unsigned SR_W   = 40;

    // Parameters below 1 would make the phase counters never terminate.
    if (SCLK_DIV < 1 || IOUPD_LEN < 1) begin : g_bad_param
        $error("ad9911_serial_writer: SCLK_DIV and IOUPD_LEN must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SH_LO,
        SH_HI,
        CS_HOLD,
        CS_REC,
        IOUPD
    } state_t;

    state_t              state_q, state_d;
    logic                tr_q;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                sdio_q, sdio_d;

    logic                start_c;
    logic [2:0]          nbytes_c;
    logic [31:0]         data_lj_c;

    assign start_c = TR & ~tr_q;

    // Natural byte count of the addressed register.
    always_comb begin
        nbytes_c = 3'd4;
        case (ADDR[4:0])
            5'h00:               nbytes_c = 3'd1;
            5'h02, 5'h05, 5'h07: nbytes_c = 3'd2;
            5'h01, 5'h03, 5'h06: nbytes_c = 3'd3;
            default:             nbytes_c = 3'd4;
        endcase
    end

    // Left-justify the low N data bytes so they follow the instruction byte.
    always_comb begin
        data_lj_c = DATA;
        case (nbytes_c)
            3'd1:    data_lj_c = {DATA[7:0],  24'h000000};
            3'd2:    data_lj_c = {DATA[15:0], 16'h0000};
            3'd3:    data_lj_c = {DATA[23:0], 8'h00};
            default: data_lj_c = DATA;
        endcase
    end

`ifdef AUTO_IO_UPDATE_EN
    localparam int unsigned UPD_W = $clog2(IOUPD_LEN) + 1;
    logic [UPD_W-1:0] upd_q, upd_d;
    logic             ioupd_q, ioupd_d;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bits_d  = bits_q;
        div_d   = div_q;
        err_d   = 1'b0;
`ifdef AUTO_IO_UPDATE_EN
        upd_d   = upd_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    if (ADDR > 8'h18) begin
                        err_d = 1'b1;
                    end else begin
                        sr_d    = {3'b000, ADDR[4:0], data_lj_c};
                        bits_d  = BITS_W'({nbytes_c, 3'b000}) + BITS_W'(8);
                        state_d = CS_SETUP;
                    end
                end
            end
            CS_SETUP: begin
                div_d   = '0;
                state_d = SH_LO;
            end
            SH_LO: begin
                if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                    div_d   = '0;
                    state_d = SH_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SH_HI: begin
                if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                    div_d   = '0;
                    sr_d    = {sr_q[SR_W-2:0], 1'b0};
                    bits_d  = bits_q - BITS_W'(1);
                    state_d = (bits_q == BITS_W'(1)) ? CS_HOLD : SH_LO;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            CS_HOLD: begin
                state_d = CS_REC;
            end
            CS_REC: begin
`ifdef AUTO_IO_UPDATE_EN
                upd_d   = '0;
                state_d = IOUPD;
`else
                state_d = IDLE;
`endif
            end
`ifdef AUTO_IO_UPDATE_EN
            IOUPD: begin
                if (upd_q == UPD_W'(IOUPD_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    upd_d = upd_q + UPD_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        sclk_d = (state_d == SH_HI);
        cs_n_d = !((state_d == CS_SETUP) || (state_d == SH_LO) ||
                   (state_d == SH_HI)    || (state_d == CS_HOLD));
        sdio_d = (state_d == SH_LO) ? sr_d[SR_W-1] : sdio_q;
`ifdef AUTO_IO_UPDATE_EN
        ioupd_d = (state_d == IOUPD);
`endif
    end

    // State, datapath and output registers; reset forces the SPI port idle at once.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            tr_q    <= 1'b0;
            sr_q    <= '0;
            bits_q  <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sdio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tr_q    <= TR;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            sdio_q  <= sdio_d;
        end
    end

`ifdef AUTO_IO_UPDATE_EN
    // IO_UPDATE strobe width counter and output register.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            upd_q   <= '0;
            ioupd_q <= 1'b0;
        end else begin
            upd_q   <= upd_d;
            ioupd_q <= ioupd_d;
        end
    end

    assign IO_UPDATE = ioupd_q;
`else
    assign IO_UPDATE = 1'b0;
`endif

    assign BUSY = busy_q;
    assign ERR  = err_q;
    assign SCLK = sclk_q;
    assign CS_N = cs_n_q;
    assign SDIO = sdio_q;

endmodule
